or1200_dfi_tagchk: RTL and testbench

OR1200_DFI_TAGCHK -- requirements
Module: or1200_dfi_tagchk

---
 rtl/or1200_dfi_tagchk_pkg.sv | 63 ++++++
 rtl/or1200_dfi_tagchk_if.sv | 30 +++
 rtl/or1200_dfi_tagram.sv | 24 ++
 rtl/or1200_dfi_tagchk.sv | 158 +++++++++++++++
 tb/tb_or1200_dfi_tagchk.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/or1200_dfi_tagchk_pkg.sv
// rtl/or1200_dfi_tagchk_pkg.sv - opcodes, lane masks, states and access decode for the DFI tag checker (HALT state only with OR1200_DFI_TRAP_EN)
package or1200_dfi_tagchk_pkg;

  localparam int LSUOP_W = 4;

  localparam logic [LSUOP_W-1:0] LSUOP_NOP = 4'b0000;
  localparam logic [LSUOP_W-1:0] LSUOP_LD  = 4'b0001;
  localparam logic [LSUOP_W-1:0] LSUOP_SD  = 4'b0011;
  localparam logic [LSUOP_W-1:0] LSUOP_LBZ = 4'b0100;
  localparam logic [LSUOP_W-1:0] LSUOP_LBS = 4'b0101;
  localparam logic [LSUOP_W-1:0] LSUOP_LHZ = 4'b0110;
  localparam logic [LSUOP_W-1:0] LSUOP_LHS = 4'b0111;
  localparam logic [LSUOP_W-1:0] LSUOP_LWZ = 4'b1000;
  localparam logic [LSUOP_W-1:0] LSUOP_LWS = 4'b1001;
  localparam logic [LSUOP_W-1:0] LSUOP_SB  = 4'b1010;
  localparam logic [LSUOP_W-1:0] LSUOP_SW  = 4'b1100;
  localparam logic [LSUOP_W-1:0] LSUOP_SH  = 4'b1110;

  localparam logic [4:0] DFI_PROT_REG_DEF = 5'd9;

  localparam logic [3:0] LANE_B0 = 4'b0001;
  localparam logic [3:0] LANE_LO = 4'b0011;
  localparam logic [3:0] LANE_HI = 4'b1100;
  localparam logic [3:0] LANE_W  = 4'b1111;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_RUN   = 2'd1
`ifdef OR1200_DFI_TRAP_EN
    , ST_HALT = 2'd2
`endif
  } dfi_state_e;

  typedef struct packed {
    logic       ok;
    logic       store;
    logic [3:0] mask;
  } lsu_dec_t;

  // Classifies a load/store opcode; misaligned half/word accesses come back not ok
  function automatic lsu_dec_t lsu_decode(input logic [LSUOP_W-1:0] op, input logic [1:0] a);
    lsu_dec_t d;
    d = '0;
    case (op)
      LSUOP_SB, LSUOP_LBZ, LSUOP_LBS: begin
        d.ok   = 1'b1;
        d.mask = LANE_B0 << a;
      end
      LSUOP_SH, LSUOP_LHZ, LSUOP_LHS: begin
        d.ok   = ~a[0];
        d.mask = a[1] ? LANE_HI : LANE_LO;
      end
      LSUOP_SW, LSUOP_LWZ, LSUOP_LWS: begin
        d.ok   = (a == 2'b00);
        d.mask = LANE_W;
      end
      default: d.ok = 1'b0;
    endcase
    d.store = (op == LSUOP_SB) || (op == LSUOP_SH) || (op == LSUOP_SW);
    return d;
  endfunction

endpackage

// File: rtl/or1200_dfi_tagchk_if.sv
// rtl/or1200_dfi_tagchk_if.sv - EX-stage access and violation report bundle for the DFI tag checker
interface or1200_dfi_tagchk_if #(parameter int CNT_W = 8);
  import or1200_dfi_tagchk_pkg::*;

  logic               ex_valid;
  logic [31:0]        ex_insn;
  logic [LSUOP_W-1:0] ex_lsu_op;
  logic [31:0]        dcpu_adr_o;
  logic [31:0]        ex_pc;
  logic [31:0]        win_base;
  logic [31:0]        win_limit;
  logic               viol_ack_i;
  logic               busy_o;
  logic               viol_o;
  logic [31:0]        viol_pc_o;
  logic [31:0]        viol_adr_o;
  logic [CNT_W-1:0]   viol_cnt_o;
  logic               trap_o;

  modport master (
    output ex_valid, ex_insn, ex_lsu_op, dcpu_adr_o, ex_pc, win_base, win_limit, viol_ack_i,
    input  busy_o, viol_o, viol_pc_o, viol_adr_o, viol_cnt_o, trap_o
  );

  modport slave (
    input  ex_valid, ex_insn, ex_lsu_op, dcpu_adr_o, ex_pc, win_base, win_limit, viol_ack_i,
    output busy_o, viol_o, viol_pc_o, viol_adr_o, viol_cnt_o, trap_o
  );

endinterface

// File: rtl/or1200_dfi_tagram.sv
// rtl/or1200_dfi_tagram.sv - tag array, 4 lane bits per word, per-lane synchronous write, asynchronous read
module or1200_dfi_tagram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [3:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [3:0]    rdata_o
);

  logic [3:0] mem_q [0:(1<<AW)-1];

  // Only enabled lanes are written so partial stores need no read-modify-write
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_i[l]) mem_q[waddr_i][l] <= wdata_i[l];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/or1200_dfi_tagchk.sv
// rtl/or1200_dfi_tagchk.sv - data-flow-integrity tag checker for the protected link register; OR1200_DFI_TRAP_EN adds the HALT/trap mechanism
module or1200_dfi_tagchk
  import or1200_dfi_tagchk_pkg::*;
#(
  parameter int         TAG_AW   = 10,
  parameter int         CNT_W    = 8,
  parameter logic [4:0] PROT_REG = DFI_PROT_REG_DEF
) (
  input logic                clk,
  input logic                rst,
  or1200_dfi_tagchk_if.slave bus
);

  localparam int TAG_DEPTH = 1 << TAG_AW;

  dfi_state_e        state_q, state_d;
  logic [TAG_AW-1:0] sweep_q, sweep_d;

  logic              s1_vld_q, s1_store_q, s1_prot_q;
  logic [TAG_AW-1:0] s1_idx_q;
  logic [3:0]        s1_mask_q;
  logic [31:0]       s1_pc_q, s1_adr_q;

  logic              viol_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [31:0]       cap_pc_q, cap_adr_q;

  lsu_dec_t          dec;
  logic [31:0]       off;
  logic              tracked, prot_hit;
  logic [3:0]        rtag, tag_we, tag_wdata;
  logic [TAG_AW-1:0] tag_waddr;
  logic              viol_d, cap_en;

  // EX-stage qualification: opcode, alignment, window bounds and table depth
  always_comb begin
    dec      = lsu_decode(bus.ex_lsu_op, bus.dcpu_adr_o[1:0]);
    off      = bus.dcpu_adr_o - bus.win_base;
    tracked  = bus.ex_valid && (state_q != ST_CLEAR) && dec.ok &&
               (bus.dcpu_adr_o >= bus.win_base) && (bus.dcpu_adr_o < bus.win_limit) &&
               (off[31:2] < 30'(TAG_DEPTH));
    prot_hit = dec.store ? (bus.ex_insn[15:11] == PROT_REG) : (bus.ex_insn[25:21] == PROT_REG);
  end

  // Stage 1: capture the qualified access for the tag lookup/update next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q   <= 1'b0;
      s1_store_q <= 1'b0;
      s1_prot_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_mask_q  <= '0;
      s1_pc_q    <= '0;
      s1_adr_q   <= '0;
    end else begin
      s1_vld_q <= tracked;
      if (tracked) begin
        s1_store_q <= dec.store;
        s1_prot_q  <= prot_hit;
        s1_idx_q   <= off[TAG_AW+1:2];
        s1_mask_q  <= dec.mask;
        s1_pc_q    <= bus.ex_pc;
        s1_adr_q   <= bus.dcpu_adr_o;
      end
    end
  end

  // Tag write port: the clear sweep owns it, otherwise stage-1 stores use it
  always_comb begin
    tag_we    = '0;
    tag_waddr = s1_idx_q;
    tag_wdata = '0;
    if (state_q == ST_CLEAR) begin
      tag_we    = LANE_W;
      tag_waddr = sweep_q;
      tag_wdata = LANE_W;
    end else if (s1_vld_q && s1_store_q) begin
      tag_we    = s1_mask_q;
      tag_wdata = {4{~s1_prot_q}};
    end
  end

  or1200_dfi_tagram #(.AW(TAG_AW)) u_tagram (
    .clk     (clk),
    .we_i    (tag_we),
    .waddr_i (tag_waddr),
    .wdata_i (tag_wdata),
    .raddr_i (s1_idx_q),
    .rdata_o (rtag)
  );

  assign viol_d = s1_vld_q && !s1_store_q && s1_prot_q && (|(rtag & s1_mask_q));

  // State and sweep pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_CLEAR;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Next state: sweep every entry once, then run; traps park in HALT until acknowledged
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cap_en  = 1'b1;
    case (state_q)
      ST_CLEAR: begin
        sweep_d = sweep_q + TAG_AW'(1);
        if (&sweep_q) state_d = ST_RUN;
      end
      ST_RUN: begin
`ifdef OR1200_DFI_TRAP_EN
        if (viol_d) state_d = ST_HALT;
`endif
      end
`ifdef OR1200_DFI_TRAP_EN
      ST_HALT: begin
        cap_en = 1'b0;
        if (bus.viol_ack_i && !viol_d) state_d = ST_RUN;
      end
`endif
      default: state_d = ST_CLEAR;
    endcase
  end

  // Violation pulse, saturating count and capture of the reported access
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      viol_q    <= 1'b0;
      cnt_q     <= '0;
      cap_pc_q  <= '0;
      cap_adr_q <= '0;
    end else begin
      viol_q <= viol_d;
      if (viol_d && !(&cnt_q)) cnt_q <= cnt_q + CNT_W'(1);
      if (viol_d && cap_en) begin
        cap_pc_q  <= s1_pc_q;
        cap_adr_q <= s1_adr_q;
      end
    end
  end

  assign bus.busy_o     = (state_q == ST_CLEAR);
  assign bus.viol_o     = viol_q;
  assign bus.viol_cnt_o = cnt_q;
  assign bus.viol_pc_o  = cap_pc_q;
  assign bus.viol_adr_o = cap_adr_q;
`ifdef OR1200_DFI_TRAP_EN
  assign bus.trap_o     = (state_q == ST_HALT);
`else
  assign bus.trap_o     = 1'b0;
`endif

endmodule

// File: tb/tb_or1200_dfi_tagchk.sv
// tb/tb_or1200_dfi_tagchk.sv - self-checking bench for or1200_dfi_tagchk (trap expectations follow OR1200_DFI_TRAP_EN)
module tb_or1200_dfi_tagchk;
  import or1200_dfi_tagchk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst2;
  int   n_chk  = 0;
  int   n_fail = 0;

  or1200_dfi_tagchk_if #(.CNT_W(8)) bus ();
  or1200_dfi_tagchk_if #(.CNT_W(2)) bus2 ();

  or1200_dfi_tagchk #(.TAG_AW(10), .CNT_W(8)) dut  (.clk(clk), .rst(rst),  .bus(bus));
  or1200_dfi_tagchk #(.TAG_AW(10), .CNT_W(2)) dut2 (.clk(clk), .rst(rst2), .bus(bus2));

  assign bus2.ex_valid   = bus.ex_valid;
  assign bus2.ex_insn    = bus.ex_insn;
  assign bus2.ex_lsu_op  = bus.ex_lsu_op;
  assign bus2.dcpu_adr_o = bus.dcpu_adr_o;
  assign bus2.ex_pc      = bus.ex_pc;
  assign bus2.win_base   = bus.win_base;
  assign bus2.win_limit  = bus.win_limit;
  assign bus2.viol_ack_i = bus.viol_ack_i;

  typedef struct {
    bit          v;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rb;
    logic [31:0] adr;
    logic [31:0] pc;
    bit          ack;
    int          want;   // 0/1 fixed expectation, -1 = ask the reference model
  } vec_t;

  typedef struct {
    bit          v;
    logic [31:0] pc;
    logic [31:0] adr;
  } exp_t;

  // reference model state
  bit          mtag [1024][4];
  logic [31:0] win_b, win_l;
  int          total;
  logic [31:0] m_pc, m_adr;
  bit          m_halt;
  bit          ack_pend;
  exp_t        e1, e2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic vec_t mk(bit v, logic [3:0] op, logic [4:0] rd, logic [4:0] rb,
                              logic [31:0] adr, logic [31:0] pc, bit ack, int want);
    vec_t a;
    a.v = v; a.op = op; a.rd = rd; a.rb = rb; a.adr = adr; a.pc = pc; a.ack = ack; a.want = want;
    return a;
  endfunction

  // Byte-level model: a store marks each touched byte clean only when it stores r9,
  // a load into r9 is a violation if any touched byte is not clean.
  function automatic bit model_access(vec_t a);
    int unsigned nbytes, word, lane0;
    bit is_store, hit;
    hit = 0;
    if (!a.v) return 0;
    case (a.op)
      LSUOP_LBZ, LSUOP_LBS, LSUOP_SB: nbytes = 1;
      LSUOP_LHZ, LSUOP_LHS, LSUOP_SH: nbytes = 2;
      LSUOP_LWZ, LSUOP_LWS, LSUOP_SW: nbytes = 4;
      default: return 0;
    endcase
    is_store = (a.op == LSUOP_SB) || (a.op == LSUOP_SH) || (a.op == LSUOP_SW);
    if ((a.adr % nbytes) != 0) return 0;
    if (a.adr < win_b || a.adr >= win_l) return 0;
    word = (a.adr - win_b) / 4;
    if (word >= 1024) return 0;
    lane0 = a.adr % 4;
    for (int i = 0; i < int'(nbytes); i++) begin
      if (is_store) mtag[word][lane0 + i] = (a.rb != 5'd9);
      else if (mtag[word][lane0 + i]) hit = 1;
    end
    return !is_store && (a.rd == 5'd9) && hit;
  endfunction

  // One EX cycle: check what the access from two cycles ago produced, then drive a new one
  task automatic cycle(input vec_t a);
    bit mv;
    int sat8, sat2;
    @(posedge clk);
    #1;
    check("viol_o", bus.viol_o, e2.v);
    check("viol_o_cnt2", bus2.viol_o, e2.v);
    if (e2.v) begin
      total++;
      if (!m_halt) begin
        m_pc  = e2.pc;
        m_adr = e2.adr;
      end
    end
`ifdef OR1200_DFI_TRAP_EN
    if (m_halt) begin
      if (ack_pend && !e2.v) m_halt = 0;
    end else if (e2.v) begin
      m_halt = 1;
    end
`endif
    sat8 = (total > 255) ? 255 : total;
    sat2 = (total > 3) ? 3 : total;
    check("viol_cnt_o", 32'(bus.viol_cnt_o), sat8);
    check("viol_cnt_o_w2", 32'(bus2.viol_cnt_o), sat2);
    check("viol_pc_o", bus.viol_pc_o, m_pc);
    check("viol_adr_o", bus.viol_adr_o, m_adr);
    check("trap_o", bus.trap_o, m_halt);
    check("busy_o_run", bus.busy_o, 0);
    e2 = e1;
    mv = model_access(a);
    e1.v   = (a.want < 0) ? mv : a.want[0];
    e1.pc  = a.pc;
    e1.adr = a.adr;
    ack_pend = a.ack;
    bus.ex_valid   = a.v;
    bus.ex_lsu_op  = a.op;
    bus.ex_insn    = {6'b0, a.rd, 5'b0, a.rb, 11'b0};
    bus.dcpu_adr_o = a.adr;
    bus.ex_pc      = a.pc;
    bus.viol_ack_i = a.ack;
    bus.win_base   = win_b;
    bus.win_limit  = win_l;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[$];
    vec_t        idle;
    vec_t        r;
    int          lo1, lo2;
    logic [3:0]  ops [13];

    ops = '{LSUOP_NOP, LSUOP_LD, LSUOP_SD, LSUOP_LBZ, LSUOP_LBS, LSUOP_LHZ, LSUOP_LHS,
            LSUOP_LWZ, LSUOP_LWS, LSUOP_SB, LSUOP_SH, LSUOP_SW, 4'b1111};
    idle = mk(0, LSUOP_NOP, 0, 0, 32'h0, 32'h0, 0, 0);
    win_b = 32'h1000; win_l = 32'h2000;
    for (int w = 0; w < 1024; w++) for (int l = 0; l < 4; l++) mtag[w][l] = 1;
    total = 0; m_pc = '0; m_adr = '0; m_halt = 0; ack_pend = 0;
    e1 = '{0, 32'h0, 32'h0}; e2 = '{0, 32'h0, 32'h0};

    bus.ex_valid = 0; bus.ex_lsu_op = LSUOP_NOP; bus.ex_insn = '0; bus.dcpu_adr_o = '0;
    bus.ex_pc = '0; bus.viol_ack_i = 0; bus.win_base = win_b; bus.win_limit = win_l;

    // reset state
    rst = 0; rst2 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 1);
    check("rst_viol", bus.viol_o, 0);
    check("rst_cnt", 32'(bus.viol_cnt_o), 0);
    check("rst_pc", bus.viol_pc_o, 0);
    check("rst_adr", bus.viol_adr_o, 0);
    check("rst_trap", bus.trap_o, 0);
    rst = 1; rst2 = 1;

    // sweep length, with the CNT_W=2 instance reset again at entry 500
    lo1 = -1; lo2 = -1;
    for (int c = 1; c <= 1600; c++) begin
      @(posedge clk);
      #1;
      if (c == 500) begin
        check("busy2_mid_sweep", bus2.busy_o, 1);
        rst2 = 0;
        #2;
        check("busy2_in_reset", bus2.busy_o, 1);
        rst2 = 1;
      end
      if (lo1 < 0 && !bus.busy_o) lo1 = c;
      if (lo2 < 0 && !bus2.busy_o) lo2 = c;
    end
    check("busy_cycles", lo1, 1024);
    check("busy2_cycles_after_restart", lo2, 1524);

    // directed vectors, window [0x1000, 0x2000)
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h1000, 32'h100, 0, 1));
    tbl.push_back(mk(1, LSUOP_SW,  0, 9, 32'h1FFC, 32'h104, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h1FFC, 32'h108, 0, 0));
    tbl.push_back(mk(1, LSUOP_SW,  0, 3, 32'h1FFC, 32'h10C, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h1FFC, 32'h110, 0, 1));
    tbl.push_back(mk(1, LSUOP_SW,  0, 9, 32'h1100, 32'h114, 0, 0));
    tbl.push_back(mk(1, LSUOP_SB,  0, 4, 32'h1102, 32'h118, 0, 0));
    tbl.push_back(mk(1, LSUOP_LHZ, 9, 0, 32'h1100, 32'h11C, 0, 0));
    tbl.push_back(mk(1, LSUOP_LHZ, 9, 0, 32'h1102, 32'h120, 0, 1));
    tbl.push_back(mk(1, LSUOP_SW,  0, 9, 32'h0FFC, 32'h124, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h0FFC, 32'h128, 0, 0));
    tbl.push_back(mk(1, LSUOP_SW,  0, 9, 32'h1000, 32'h12C, 0, 0));
    tbl.push_back(mk(1, LSUOP_SW,  0, 3, 32'h2000, 32'h130, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h1000, 32'h134, 0, 0));
    tbl.push_back(mk(0, LSUOP_SW,  0, 9, 32'h1200, 32'h138, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h1200, 32'h13C, 0, 1));
    tbl.push_back(mk(1, LSUOP_LWZ, 5, 0, 32'h1FFC, 32'h140, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWZ, 9, 0, 32'h1102, 32'h144, 0, 0));
    tbl.push_back(mk(1, LSUOP_LBZ, 9, 0, 32'h1101, 32'h148, 0, 0));
    tbl.push_back(mk(1, LSUOP_LBS, 9, 0, 32'h1103, 32'h14C, 0, 0));
    tbl.push_back(mk(1, LSUOP_LHS, 9, 0, 32'h1202, 32'h150, 0, 1));
    tbl.push_back(mk(1, LSUOP_SH,  0, 9, 32'h1202, 32'h154, 0, 0));
    tbl.push_back(mk(1, LSUOP_LWS, 9, 0, 32'h1200, 32'h158, 0, 1));
    tbl.push_back(idle);
    tbl.push_back(idle);
    foreach (tbl[i]) cycle(tbl[i]);

    // two violations, then ack racing a third, then ack alone
    cycle(mk(0, LSUOP_NOP, 0, 0, 32'h0, 32'h0, 1, 0));
    cycle(idle);
    cycle(mk(1, LSUOP_LWZ, 9, 0, 32'h1FFC, 32'h200, 0, 1));
    cycle(mk(1, LSUOP_LWZ, 9, 0, 32'h1FFC, 32'h300, 0, 1));
    cycle(idle);
    cycle(idle);
`ifdef OR1200_DFI_TRAP_EN
    check("trap_after_two", bus.trap_o, 1);
    check("pc_frozen_first", bus.viol_pc_o, 32'h200);
`else
    check("trap_tied_low", bus.trap_o, 0);
    check("pc_latest", bus.viol_pc_o, 32'h300);
`endif
    cycle(mk(1, LSUOP_LWZ, 9, 0, 32'h1FFC, 32'h400, 0, 1));
    cycle(mk(0, LSUOP_NOP, 0, 0, 32'h0, 32'h0, 1, 0));
    cycle(idle);
    cycle(idle);
`ifdef OR1200_DFI_TRAP_EN
    check("trap_ack_with_viol", bus.trap_o, 1);
`endif
    cycle(mk(0, LSUOP_NOP, 0, 0, 32'h0, 32'h0, 1, 0));
    cycle(idle);
    cycle(idle);
    check("trap_after_ack", bus.trap_o, 0);
    cycle(mk(1, LSUOP_SW,  0, 3, 32'h1FFC, 32'h500, 0, 0));
    cycle(mk(1, LSUOP_LWZ, 9, 0, 32'h1FFC, 32'h504, 0, 1));
    cycle(idle);
    cycle(idle);
    check("capture_adr", bus.viol_adr_o, 32'h1FFC);
    check("capture_pc", bus.viol_pc_o, 32'h504);

    // randomized traffic, window extended past the table depth
    win_l = 32'h2400;
    cycle(idle);
    for (int k = 0; k < 600; k++) begin
      r.v   = ($urandom_range(0, 9) != 0);
      r.op  = ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 1) == 1)
        r.adr = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      else
        r.adr = 32'h0FF0 + 32'($urandom_range(0, 32'h1420));
      r.rd   = ($urandom_range(0, 1) == 1) ? 5'd9 : 5'($urandom_range(0, 31));
      r.rb   = ($urandom_range(0, 1) == 1) ? 5'd9 : 5'($urandom_range(0, 31));
      r.pc   = $urandom;
      r.ack  = ($urandom_range(0, 7) == 0);
      r.want = -1;
      cycle(r);
    end
    cycle(idle);
    cycle(idle);
    cycle(idle);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
